// File: rtl/gal_prog_seq.sv
// gal_prog_seq: row-sequential GAL fuse programming controller (load, shift, pulse, optional readback).
// Build option: define GAL_PROG_VERIFY_EN to include the VERIFY readback/compare stage.
//   state  | meaning
//   IDLE   | waiting for start
//   LOAD   | row_ready high, waiting for a host row
//   SHIFT  | serialising the row LSB first, two cycles per bit
//   PULSE  | pgm high for PULSE_CYCLES cycles
//   GAP    | one quiet cycle after the pulse
//   VERIFY | settle cycle, then readback and compare (GAL_PROG_VERIFY_EN only)
//   NEXT   | advance the address or finish
//   FIN    | one-cycle done, back to IDLE
module gal_prog_seq #(
  parameter int COLS         = 32,
  parameter int ROW_BITS     = 6,
  parameter int PULSE_CYCLES = 16
) (
  input  logic                C,
  input  logic                R,
  input  logic                start,
  input  logic [ROW_BITS-1:0] row_first,
  input  logic [ROW_BITS-1:0] row_last,
  output logic                busy,
  output logic                done,
  output logic                err,
  input  logic [COLS-1:0]     row_data,
  input  logic                row_valid,
  output logic                row_ready,
  output logic [ROW_BITS-1:0] addr,
  output logic                sdin,
  output logic                sclk,
  output logic                pgm,
  output logic                rd,
  input  logic                sdout
);

  localparam int CNT_MAX = (2 * COLS > PULSE_CYCLES) ? 2 * COLS : PULSE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_SHIFT = CW'(2 * COLS - 1);
  localparam logic [CW-1:0] CNT_PULSE = CW'(PULSE_CYCLES - 1);
`ifdef GAL_PROG_VERIFY_EN
  localparam logic [CW-1:0] CNT_VFY   = CW'(2 * COLS);
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SHIFT, S_PULSE, S_GAP, S_VERIFY, S_NEXT, S_FIN
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [COLS-1:0]     sr_q, sr_d;
  logic [ROW_BITS-1:0] addr_q, addr_d;
  logic [ROW_BITS-1:0] last_q, last_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                row_ready_q, row_ready_d;
  logic                sdin_q, sdin_d;
  logic                sclk_q, sclk_d;
  logic                pgm_q, pgm_d;
  logic                rd_q, rd_d;
`ifdef GAL_PROG_VERIFY_EN
  logic [COLS-1:0]     row_q, row_d;
`else
  logic                sdout_unused;
  assign sdout_unused = sdout;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    addr_d  = addr_q;
    last_d  = last_q;
    err_d   = err_q;
`ifdef GAL_PROG_VERIFY_EN
    row_d   = row_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (row_first <= row_last) begin
            last_d  = row_last;
            addr_d  = row_first;
            err_d   = 1'b0;
            state_d = S_LOAD;
          end else begin
            err_d   = 1'b1;
            state_d = S_FIN;
          end
        end
      end
      S_LOAD: begin
        if (row_valid && row_ready_q) begin
          sr_d    = row_data;
`ifdef GAL_PROG_VERIFY_EN
          row_d   = row_data;
`endif
          cnt_d   = CNT_SHIFT;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (sclk_q) sr_d = sr_q >> 1;
        if (cnt_q == '0) begin
          cnt_d   = CNT_PULSE;
          state_d = S_PULSE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_PULSE: begin
        if (cnt_q == '0) state_d = S_GAP;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_GAP: begin
`ifdef GAL_PROG_VERIFY_EN
        cnt_d   = CNT_VFY;
        sr_d    = row_q;
        state_d = S_VERIFY;
`else
        state_d = S_NEXT;
`endif
      end
`ifdef GAL_PROG_VERIFY_EN
      S_VERIFY: begin
        // sclk_q high marks the cycle in which the device presents bit k on sdout
        if (sclk_q) begin
          if (sdout != sr_q[0]) err_d = 1'b1;
          sr_d = sr_q >> 1;
        end
        if (cnt_q == '0) state_d = S_NEXT;
        else             cnt_d   = cnt_q - CW'(1);
      end
`endif
      S_NEXT: begin
        if (err_q || (addr_q == last_q)) begin
          state_d = S_FIN;
        end else begin
          addr_d  = addr_q + ROW_BITS'(1);
          state_d = S_LOAD;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so every pin comes straight from a flop.
    busy_d      = (state_d != S_IDLE) && (state_d != S_FIN);
    done_d      = (state_d == S_FIN);
    row_ready_d = (state_d == S_LOAD);
    sdin_d      = 1'b0;
    sclk_d      = 1'b0;
    pgm_d       = 1'b0;
    rd_d        = 1'b0;
    case (state_d)
      S_SHIFT: begin
        sdin_d = sr_d[0];
        sclk_d = ~cnt_d[0];
      end
      S_PULSE: pgm_d = 1'b1;
`ifdef GAL_PROG_VERIFY_EN
      S_VERIFY: begin
        rd_d   = 1'b1;
        sclk_d = ~cnt_d[0] && (cnt_d != CNT_VFY);
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge C) begin
    if (R) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      sr_q        <= '0;
      addr_q      <= '0;
      last_q      <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      row_ready_q <= 1'b0;
      sdin_q      <= 1'b0;
      sclk_q      <= 1'b0;
      pgm_q       <= 1'b0;
      rd_q        <= 1'b0;
`ifdef GAL_PROG_VERIFY_EN
      row_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      addr_q      <= addr_d;
      last_q      <= last_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      row_ready_q <= row_ready_d;
      sdin_q      <= sdin_d;
      sclk_q      <= sclk_d;
      pgm_q       <= pgm_d;
      rd_q        <= rd_d;
`ifdef GAL_PROG_VERIFY_EN
      row_q       <= row_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign row_ready = row_ready_q;
  assign addr      = addr_q;
  assign sdin      = sdin_q;
  assign sclk      = sclk_q;
  assign pgm       = pgm_q;
  assign rd        = rd_q;

endmodule
